// File: rtl/ghash_core.sv
// ghash_core: digit-serial GHASH engine, Y = (Y ^ X_i) * H over GF(2^128).
// Optional feature macro: GHASH_LEN_BLK_EN (in-block length-block generation).
module ghash_core #(
  parameter int unsigned DIGIT_BITS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] h_key,
  input  logic         h_load,
  input  logic [127:0] in_blk,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic         in_is_aad,
  input  logic [4:0]   in_nbytes,
  output logic [127:0] out_ghash,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned GHASH_BITS = 128;
  localparam int unsigned N_DIGITS   = GHASH_BITS / DIGIT_BITS;
  localparam int unsigned CNT_W      = $clog2(N_DIGITS + 1);
  localparam logic [127:0] R_POLY    = {8'hE1, 120'b0};

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_LEN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [127:0]       y_q, y_d, h_q, h_d, x_q, x_d, z_q, z_d, v_q, v_d;
  logic               h_valid_q, h_valid_d, last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       z_step, v_step, x_step;
  logic               accept;

`ifdef GHASH_LEN_BLK_EN
  logic [63:0]        aad_q, aad_d, ct_q, ct_d;
`else
  logic               unused_len;
  assign unused_len = ^{in_nbytes, in_is_aad};
`endif

  // Status outputs decoded from registered state only
  assign in_ready  = (state_q == S_IDLE) && h_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_ghash = out_valid ? y_q : '0;
  assign accept    = in_valid && in_ready && !h_load;

  // One digit of the shift-and-add multiply, MSB of X first
  always_comb begin
    z_step = z_q;
    v_step = v_q;
    x_step = x_q;
    for (int i = 0; i < int'(DIGIT_BITS); i++) begin
      if (x_step[127]) z_step = z_step ^ v_step;
      v_step = v_step[0] ? ((v_step >> 1) ^ R_POLY) : (v_step >> 1);
      x_step = {x_step[126:0], 1'b0};
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    h_d       = h_q;
    h_valid_d = h_valid_q;
    x_d       = x_q;
    z_d       = z_q;
    v_d       = v_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
`ifdef GHASH_LEN_BLK_EN
    aad_d     = aad_q;
    ct_d      = ct_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (h_load) begin
          h_d       = h_key;
          h_valid_d = 1'b1;
        end else if (accept) begin
          x_d     = y_q ^ in_blk;
          z_d     = '0;
          v_d     = h_q;
          cnt_d   = '0;
          last_d  = in_last;
          state_d = S_MULT;
`ifdef GHASH_LEN_BLK_EN
          if (in_is_aad) aad_d = aad_q + (64'(in_nbytes) << 3);
          else           ct_d  = ct_q + (64'(in_nbytes) << 3);
`endif
        end
      end
      S_MULT, S_LEN: begin
        if (cnt_q == CNT_W'(N_DIGITS)) begin
          // Writeback cycle: commit product, pick the follow-on state
          y_d = z_q;
          if (state_q == S_LEN) begin
            state_d = S_DONE;
          end else if (last_q) begin
`ifdef GHASH_LEN_BLK_EN
            x_d     = z_q ^ {aad_q, ct_q};
            z_d     = '0;
            v_d     = h_q;
            cnt_d   = '0;
            state_d = S_LEN;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          z_d   = z_step;
          v_d   = v_step;
          x_d   = x_step;
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          y_d     = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = S_IDLE;
`ifdef GHASH_LEN_BLK_EN
          aad_d   = '0;
          ct_d    = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      y_q       <= '0;
      h_q       <= '0;
      h_valid_q <= 1'b0;
      x_q       <= '0;
      z_q       <= '0;
      v_q       <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
`ifdef GHASH_LEN_BLK_EN
      aad_q     <= '0;
      ct_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      h_q       <= h_d;
      h_valid_q <= h_valid_d;
      x_q       <= x_d;
      z_q       <= z_d;
      v_q       <= v_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
`ifdef GHASH_LEN_BLK_EN
      aad_q     <= aad_d;
      ct_q      <= ct_d;
`endif
    end
  end

endmodule

// File: tb/tb_ghash_core.sv
// Directed bench for ghash_core (default build, length-block generation off).
module tb_ghash_core;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] h_key, in_blk;
  logic         h_load, in_valid, aux_valid, in_last, in_is_aad, out_ready;
  logic [4:0]   in_nbytes;

  logic [127:0] out_ghash, og_a, og_b;
  logic         in_ready, out_valid, busy;
  logic         ir_a, ov_a, busy_a, ir_b, ov_b, busy_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ghash_core #(.DIGIT_BITS(8)) u_dut (
    .clk(clk), .reset(reset), .h_key(h_key), .h_load(h_load), .in_blk(in_blk),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_is_aad(in_is_aad),
    .in_nbytes(in_nbytes), .out_ghash(out_ghash), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy));

  ghash_core #(.DIGIT_BITS(1)) u_d1 (
    .clk(clk), .reset(reset), .h_key(h_key), .h_load(h_load), .in_blk(in_blk),
    .in_valid(aux_valid), .in_ready(ir_a), .in_last(in_last), .in_is_aad(in_is_aad),
    .in_nbytes(in_nbytes), .out_ghash(og_a), .out_valid(ov_a),
    .out_ready(out_ready), .busy(busy_a));

  ghash_core #(.DIGIT_BITS(32)) u_d32 (
    .clk(clk), .reset(reset), .h_key(h_key), .h_load(h_load), .in_blk(in_blk),
    .in_valid(aux_valid), .in_ready(ir_b), .in_last(in_last), .in_is_aad(in_is_aad),
    .in_nbytes(in_nbytes), .out_ghash(og_b), .out_valid(ov_b),
    .out_ready(out_ready), .busy(busy_b));

  typedef struct {
    string        name;
    logic [127:0] h;
    int           nblk;
    logic [127:0] b0, b1, b2;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] H_ONE = 128'h80000000_00000000_00000000_00000000;
  localparam logic [127:0] H_X   = 128'h40000000_00000000_00000000_00000000;
  localparam logic [127:0] BLK_A = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] BLK_B = 128'h11111111_22222222_33333333_44444444;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic load_h(input logic [127:0] k);
    h_key  = k;
    h_load = 1'b1;
    tick();
    h_load = 1'b0;
  endtask

  task automatic send_blk(input string nm, input logic [127:0] blk, input logic last);
    bit got = 0;
    in_blk   = blk;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin
        got = 1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout got=0 exp=1", nm);
    end
  endtask

  task automatic wait_out(input string nm, output logic [127:0] res);
    bit got = 0;
    res = '0;
    for (int i = 0; i < 400; i++) begin
      if (out_valid) begin
        got = 1;
        break;
      end
      tick();
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_out_timeout got=0 exp=1", nm);
    end else begin
      res = out_ghash;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  vec_t vecs[6];
  logic [127:0] res;
  int lat_a, lat_m, lat_b;

  initial begin
    vecs[0] = '{"identity", H_ONE, 1, BLK_A, 128'h0, 128'h0, BLK_A};
    vecs[1] = '{"zero_key", 128'h0, 3, BLK_A, BLK_B, 128'hdeadbeef, 128'h0};
    vecs[2] = '{"nist_tc2", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2,
                128'h0388dace60b6a392f328c2b971b2fe78,
                128'h00000000000000000000000000000080, 128'h0,
                128'hf38cbb1ad69223dcc3457ae5b6b0f885};
    vecs[3] = '{"h_one_xor3", H_ONE, 3, BLK_B,
                128'h01010101_01010101_01010101_01010101,
                128'h10000000_00000000_00000000_00000001,
                128'h00101010_23232323_32323232_45454544};
    vecs[4] = '{"h_x_reduce", H_X, 1, 128'h3, 128'h0, 128'h0,
                128'he1000000_00000000_00000000_00000001};
    vecs[5] = '{"h_x_shift", H_X, 1, H_ONE, 128'h0, 128'h0, H_X};

    reset = 1'b1; h_key = '0; in_blk = '0; h_load = 0; in_valid = 0; aux_valid = 0;
    in_last = 0; in_is_aad = 0; in_nbytes = 5'd16; out_ready = 0;
    repeat (3) tick();
    check("rst_in_ready", 128'(in_ready), 128'h0);
    check("rst_out_valid", 128'(out_valid), 128'h0);
    check("rst_out_ghash", out_ghash, 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    reset = 1'b0;
    tick();
    check("no_key_in_ready", 128'(in_ready), 128'h0);

    // Table-driven messages; each one also proves Y restarts at zero
    for (int v = 0; v < 6; v++) begin
      load_h(vecs[v].h);
      send_blk(vecs[v].name, vecs[v].b0, vecs[v].nblk == 1);
      if (vecs[v].nblk > 1) send_blk(vecs[v].name, vecs[v].b1, vecs[v].nblk == 2);
      if (vecs[v].nblk > 2) send_blk(vecs[v].name, vecs[v].b2, 1'b1);
      wait_out(vecs[v].name, res);
      check(vecs[v].name, res, vecs[v].exp);
    end

    // Same-cycle h_load and in_valid: key loads, block not taken
    load_h(H_ONE);
    h_key = H_X; h_load = 1'b1; in_blk = H_ONE; in_last = 1'b1; in_valid = 1'b1;
    tick();
    h_load = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("hload_blocks_accept", 128'(busy), 128'h0);
    send_blk("hload_newkey", H_ONE, 1'b1);
    wait_out("hload_newkey", res);
    check("hload_newkey", res, H_X);

    // Backpressure: result held, h_load ignored, then next message restarts Y
    load_h(H_ONE);
    send_blk("bp1", BLK_A, 1'b1);
    for (int i = 0; i < 400 && !out_valid; i++) tick();
    check("bp_out_valid", 128'(out_valid), 128'h1);
    h_key = 128'h0;
    for (int i = 0; i < 5; i++) begin
      h_load = 1'b1;
      tick();
    end
    h_load = 1'b0;
    check("bp_hold_ghash", out_ghash, BLK_A);
    check("bp_hold_valid", 128'(out_valid), 128'h1);
    check("bp_in_ready", 128'(in_ready), 128'h0);
    wait_out("bp1", res);
    send_blk("bp2", BLK_B, 1'b1);
    wait_out("bp2", res);
    check("bp_second_msg", res, BLK_B);

    // Latency per digit width: three engines accept the same block together
    load_h(H_ONE);
    in_blk = BLK_A; in_last = 1'b0; in_valid = 1'b1; aux_valid = 1'b1;
    check("lat_all_ready", 128'({ir_a, in_ready, ir_b}), 128'h7);
    tick();
    in_valid = 1'b0; aux_valid = 1'b0;
    lat_a = 0; lat_m = 0; lat_b = 0;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (ir_a && lat_a == 0) lat_a = k;
      if (in_ready && lat_m == 0) lat_m = k;
      if (ir_b && lat_b == 0) lat_b = k;
    end
    check("lat_d1", 128'(lat_a), 128'd129);
    check("lat_d8", 128'(lat_m), 128'd17);
    check("lat_d32", 128'(lat_b), 128'd5);
    in_blk = BLK_B; in_last = 1'b1; in_valid = 1'b1; aux_valid = 1'b1;
    tick();
    in_valid = 1'b0; aux_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 200 && !(ov_a && out_valid && ov_b); i++) tick();
    check("lat_d1_result", og_a, BLK_A ^ BLK_B);
    check("lat_d8_result", out_ghash, BLK_A ^ BLK_B);
    check("lat_d32_result", og_b, BLK_A ^ BLK_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while a result is pending drops out_valid without a clock
    send_blk("rst_done", BLK_A, 1'b1);
    for (int i = 0; i < 400 && !out_valid; i++) tick();
    reset = 1'b1;
    #1;
    check("rst_done_out_valid", 128'(out_valid), 128'h0);
    tick();
    reset = 1'b0;

    // Reset mid-multiply at digit 3
    load_h(H_ONE);
    send_blk("rst_mult", BLK_B, 1'b1);
    repeat (3) tick();
    check("rst_mult_busy_before", 128'(busy), 128'h1);
    reset = 1'b1;
    #1;
    check("rst_mult_busy", 128'(busy), 128'h0);
    check("rst_mult_out_valid", 128'(out_valid), 128'h0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("rst_mult_in_ready", 128'(in_ready), 128'h0);
    check("rst_mult_no_result", 128'(out_valid), 128'h0);
    load_h(H_ONE);
    send_blk("rst_rerun", BLK_A, 1'b1);
    wait_out("rst_rerun", res);
    check("rst_rerun_identity", res, BLK_A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
